// File: rtl/inst_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inst_fetch_queue                                           |
// | Description : Instruction fetch front end. Owns the PC, issues one-word  |
// |               fetch requests to the I-cache with a single request       |
// |               outstanding, buffers returned words in a DEPTH-entry FIFO  |
// |               and presents the head entry to the decoder. Decoder and    |
// |               ROB redirects flush the queue and drop stale responses.    |
// | Options     : IF_PERF_CNT_EN - adds perf_fetched / perf_flushed counters |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module inst_fetch_queue #(
   parameter int unsigned DEPTH    = 4,       // queue entries, power of two, >= 2
   parameter logic [31:0] RESET_PC = 32'h0    // PC loaded at reset
) (
   input  logic        clk_in,
   input  logic        rst_in,         // asynchronous, active-low
   input  logic        rdy_in,         // low freezes all state

   // I-cache request / response
   output logic        ic_req_valid,
   output logic [31:0] ic_req_addr,
   input  logic        ic_req_ready,
   input  logic        ic_resp_valid,
   input  logic [31:0] ic_resp_data,

   // decoder side
   output logic        dec_valid,
   output logic [31:0] dec_inst_addr,
   output logic [31:0] dec_inst,
   input  logic        dec_accept,
   input  logic        dec_clear,
   input  logic [31:0] dec_set_addr,

   // ROB flush
   input  logic        rob_clear,
   input  logic [31:0] rob_set_addr
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed
`endif
);

   // -----------------------------------------------------------------------
   // Constants
   // -----------------------------------------------------------------------
   localparam int unsigned          c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned          c_CNT_W     = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0]   c_DEPTH_CNT = c_CNT_W'(DEPTH);
   localparam logic [c_PTR_W-1:0]   c_PTR_ONE   = c_PTR_W'(1);
   localparam logic [c_CNT_W-1:0]   c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [31:0]          c_ALIGN     = 32'hFFFF_FFFC;

   // Fetch FSM encoding
   localparam logic [1:0] c_ST_IDLE = 2'd0;   // decide whether to fetch
   localparam logic [1:0] c_ST_REQ  = 2'd1;   // request presented, waiting for accept
   localparam logic [1:0] c_ST_WAIT = 2'd2;   // request accepted, waiting for data

   // -----------------------------------------------------------------------
   // State
   // -----------------------------------------------------------------------
   logic [1:0]          r_state;
   logic [31:0]         r_pc;
   logic                r_req_valid;
   logic [31:0]         r_req_addr;
   logic                r_drop_resp;      // one in-flight response must be discarded
   logic [c_PTR_W-1:0]  r_head;
   logic [c_PTR_W-1:0]  r_tail;
   logic [c_CNT_W-1:0]  r_count;
   logic [31:0]         r_addr_q [DEPTH];
   logic [31:0]         r_data_q [DEPTH];

   // -----------------------------------------------------------------------
   // Combinational control
   // -----------------------------------------------------------------------
   logic                w_redirect;
   logic [31:0]         w_target_raw;
   logic [31:0]         w_target;
   logic                w_empty;
   logic                w_has_space;
   logic                w_req_fire;
   logic                w_resp_live;
   logic                w_push;
   logic                w_pop;
   logic                w_issue;
   logic                w_outstanding_after;
   logic [1:0]          w_state_nxt;

   // A redirect from either source; the ROB wins when both fire together.
   assign w_redirect   = rdy_in & (rob_clear | dec_clear);
   assign w_target_raw = rob_clear ? rob_set_addr : dec_set_addr;
   assign w_target     = w_target_raw & c_ALIGN;

   assign w_empty      = (r_count == '0);
   assign w_has_space  = (r_count < c_DEPTH_CNT);

   // Request handshake only happens while the request is presented.
   assign w_req_fire   = rdy_in & r_req_valid & ic_req_ready;

   // A response is only meaningful when one is actually outstanding: either
   // the normal WAIT state or a dropped request still in flight after a flush.
   assign w_resp_live  = rdy_in & ic_resp_valid & ((r_state == c_ST_WAIT) | r_drop_resp);

   // Redirect overrides both the push of a same-cycle response and any pop.
   assign w_push       = w_resp_live & ~r_drop_resp & ~w_redirect;
   assign w_pop        = rdy_in & dec_accept & ~w_empty & ~w_redirect;

   // New request only with room guaranteed for its response and nothing in
   // flight (a dropped response still counts as in flight).
   assign w_issue      = rdy_in & (r_state == c_ST_IDLE) & ~r_drop_resp
                         & w_has_space & ~w_redirect;

   // Whether a response will still be owed to us after this cycle; on a
   // redirect that response becomes stale and has to be dropped.
   assign w_outstanding_after = ((r_state == c_ST_WAIT) & ~w_resp_live)
                              | w_req_fire
                              | (r_drop_resp & ~w_resp_live);

   // Next fetch state; any redirect returns to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      if (w_redirect) begin
         w_state_nxt = c_ST_IDLE;
      end else begin
         case (r_state)
            c_ST_IDLE: if (w_issue)     w_state_nxt = c_ST_REQ;
            c_ST_REQ:  if (w_req_fire)  w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (w_resp_live) w_state_nxt = c_ST_IDLE;
            default:                    w_state_nxt = c_ST_IDLE;
         endcase
      end
   end

   // Fetch FSM, request registers and the stale-response flag.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state     <= c_ST_IDLE;
         r_req_valid <= 1'b0;
         r_req_addr  <= RESET_PC;
         r_drop_resp <= 1'b0;
      end else if (rdy_in) begin
         r_state <= w_state_nxt;

         if (w_redirect) begin
            r_req_valid <= 1'b0;
         end else if (w_issue) begin
            r_req_valid <= 1'b1;
            r_req_addr  <= r_pc;
         end else if (w_req_fire) begin
            r_req_valid <= 1'b0;
         end

         if (w_redirect) begin
            r_drop_resp <= w_outstanding_after;
         end else if (w_resp_live & r_drop_resp) begin
            r_drop_resp <= 1'b0;
         end
      end
   end

   // Program counter: redirect target, or advance once a request is accepted.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_pc <= RESET_PC;
      end else if (rdy_in) begin
         if (w_redirect) begin
            r_pc <= w_target;
         end else if (w_req_fire) begin
            r_pc <= r_pc + 32'd4;
         end
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (rdy_in) begin
         if (w_redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_tail <= r_tail + c_PTR_ONE;
            if (w_pop)  r_head <= r_head + c_PTR_ONE;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + c_CNT_ONE;
               2'b01:   r_count <= r_count - c_CNT_ONE;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Entry storage: write the returned word and its fetch address at the tail.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_addr_q[i] <= '0;
            r_data_q[i] <= '0;
         end
      end else if (w_push) begin
         r_addr_q[r_tail] <= r_req_addr;
         r_data_q[r_tail] <= ic_resp_data;
      end
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign ic_req_valid  = r_req_valid;
   assign ic_req_addr   = r_req_addr;
   assign dec_valid     = ~w_empty;
   assign dec_inst_addr = r_addr_q[r_head];
   assign dec_inst      = r_data_q[r_head];

`ifdef IF_PERF_CNT_EN
   // -----------------------------------------------------------------------
   // Performance counters
   // -----------------------------------------------------------------------
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_flushed;
   logic        w_resp_drop;
   logic [31:0] w_flush_entries;

   // Responses discarded either because they were already stale or because
   // they land in the redirect cycle itself.
   assign w_resp_drop     = w_resp_live & (r_drop_resp | w_redirect);
   assign w_flush_entries = w_redirect ? {{(32 - c_CNT_W){1'b0}}, r_count} : 32'd0;

   // Count pushed instructions and discarded work; both wrap naturally.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_perf_fetched <= 32'd0;
         r_perf_flushed <= 32'd0;
      end else if (rdy_in) begin
         r_perf_fetched <= r_perf_fetched + {31'd0, w_push};
         r_perf_flushed <= r_perf_flushed + w_flush_entries + {31'd0, w_resp_drop};
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_flushed = r_perf_flushed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_inst_fetch_queue                                        |
// | Description : Self-checking bench for inst_fetch_queue (DEPTH=4,         |
// |               RESET_PC=0x1000). Table-driven streaming vectors followed  |
// |               by directed fill, redirect, freeze and wrap sequences.     |
// |               Honours IF_PERF_CNT_EN when defined.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_inst_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_1000;
   localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        ic_req_valid;
   logic [31:0] ic_req_addr;
   logic        ic_req_ready;
   logic        ic_resp_valid;
   logic [31:0] ic_resp_data;
   logic        dec_valid;
   logic [31:0] dec_inst_addr;
   logic [31:0] dec_inst;
   logic        dec_accept;
   logic        dec_clear;
   logic [31:0] dec_set_addr;
   logic        rob_clear;
   logic [31:0] rob_set_addr;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushed;
`endif

   always #5 clk_in = ~clk_in;

   inst_fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RPC)
   ) u_dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .ic_req_valid  (ic_req_valid),
      .ic_req_addr   (ic_req_addr),
      .ic_req_ready  (ic_req_ready),
      .ic_resp_valid (ic_resp_valid),
      .ic_resp_data  (ic_resp_data),
      .dec_valid     (dec_valid),
      .dec_inst_addr (dec_inst_addr),
      .dec_inst      (dec_inst),
      .dec_accept    (dec_accept),
      .dec_clear     (dec_clear),
      .dec_set_addr  (dec_set_addr),
      .rob_clear     (rob_clear),
      .rob_set_addr  (rob_set_addr)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_flushed  (perf_flushed)
`endif
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Cache model state and logs of observed handshakes
   logic        pend;
   logic [31:0] pend_addr;
   logic        hold_resp;
   int          resp_cnt;
   logic [31:0] req_log  [$];
   logic [31:0] pop_addr [$];
   logic [31:0] pop_inst [$];

   typedef struct {
      logic        rdy;     // ic_req_ready
      logic        rv;      // ic_resp_valid
      logic [31:0] rd;      // ic_resp_data
      logic        acc;     // dec_accept
      logic        e_qv;    // expected ic_req_valid
      logic [31:0] e_qa;    // expected ic_req_addr
      logic        e_dv;    // expected dec_valid
      logic [31:0] e_da;    // expected dec_inst_addr (when e_dv)
      logic [31:0] e_di;    // expected dec_inst (when e_dv)
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] qat(input logic [31:0] q [$], input int i);
      return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // One clock with the cache model: always ready, data returned the cycle
   // after acceptance unless hold_resp stalls it.
   task automatic cyc();
      logic        fire;
      logic        taken;
      logic [31:0] a;
      ic_resp_valid = pend & ~hold_resp;
      ic_resp_data  = pend ? (pend_addr ^ KEY) : 32'h0;
      fire  = ic_req_valid & ic_req_ready & rdy_in;
      a     = ic_req_addr;
      taken = ic_resp_valid & rdy_in;
      if (rdy_in && dec_accept && dec_valid) begin
         pop_addr.push_back(dec_inst_addr);
         pop_inst.push_back(dec_inst);
      end
      tick();
      if (taken) begin
         pend = 1'b0;
         resp_cnt++;
      end
      if (fire) begin
         pend      = 1'b1;
         pend_addr = a;
         req_log.push_back(a);
      end
   endtask

   task automatic do_reset();
      rst_in        = 1'b0;
      rdy_in        = 1'b1;
      ic_req_ready  = 1'b1;
      ic_resp_valid = 1'b0;
      ic_resp_data  = 32'h0;
      dec_accept    = 1'b0;
      dec_clear     = 1'b0;
      dec_set_addr  = 32'h0;
      rob_clear     = 1'b0;
      rob_set_addr  = 32'h0;
      hold_resp     = 1'b0;
      pend          = 1'b0;
      pend_addr     = 32'h0;
      resp_cnt      = 0;
      req_log.delete();
      pop_addr.delete();
      pop_inst.delete();
      #1;
      chk("rst_async_dec_valid", dec_valid, 1'b0);
      chk("rst_async_req_valid", ic_req_valid, 1'b0);
      tick();
      tick();
      chk("rst_req_addr", ic_req_addr, RPC);
      chk("rst_dec_addr", dec_inst_addr, 32'h0);
      chk("rst_dec_inst", dec_inst, 32'h0);
`ifdef IF_PERF_CNT_EN
      chk("rst_perf_fetched", perf_fetched, 32'h0);
      chk("rst_perf_flushed", perf_flushed, 32'h0);
`endif
      rst_in = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int          b;
      logic [31:0] a;

      // Streaming vectors: IDLE->REQ->WAIT per word, accept held high,
      // response one cycle after acceptance.
      for (int n = 0; n < 4; n++) begin
         a = RPC + 32'(4 * n);
         tbl[3*n+0] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, a, 1'b0, 32'h0, 32'h0};
         tbl[3*n+1] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, a, 1'b0, 32'h0, 32'h0};
         tbl[3*n+2] = '{1'b1, 1'b1, a ^ KEY, 1'b1, 1'b0, a, 1'b1, a,     a ^ KEY};
      end

      rst_in = 1'b1;
      #2;
      do_reset();

      // ---- table-driven streaming ----
      for (int i = 0; i < 12; i++) begin
         ic_req_ready  = tbl[i].rdy;
         ic_resp_valid = tbl[i].rv;
         ic_resp_data  = tbl[i].rd;
         dec_accept    = tbl[i].acc;
         tick();
         chk($sformatf("vec%0d_req_valid", i), ic_req_valid, tbl[i].e_qv);
         chk($sformatf("vec%0d_req_addr", i),  ic_req_addr,  tbl[i].e_qa);
         chk($sformatf("vec%0d_dec_valid", i), dec_valid,    tbl[i].e_dv);
         if (tbl[i].e_dv) begin
            chk($sformatf("vec%0d_dec_addr", i), dec_inst_addr, tbl[i].e_da);
            chk($sformatf("vec%0d_dec_inst", i), dec_inst,      tbl[i].e_di);
         end
      end
`ifdef IF_PERF_CNT_EN
      chk("stream_perf_fetched", perf_fetched, 32'd4);
`endif

      // ---- fill to DEPTH with no accepts, then one accept ----
      do_reset();
      repeat (25) cyc();
      chk("fill_req_count", req_log.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("fill_req%0d", i), qat(req_log, i), RPC + 32'(4 * i));
      chk("fill_req_valid", ic_req_valid, 1'b0);
      chk("fill_dec_valid", dec_valid, 1'b1);
      chk("fill_head", dec_inst_addr, RPC);
      dec_accept = 1'b1;
      cyc();
      dec_accept = 1'b0;
      repeat (10) cyc();
      chk("fill_req_count2", req_log.size(), 5);
      chk("fill_req4", qat(req_log, 4), 32'h0000_1010);
      chk("fill_pop0", qat(pop_addr, 0), RPC);
      chk("fill_head2", dec_inst_addr, 32'h0000_1004);

      // ---- decoder redirect with 3 buffered entries ----
      do_reset();
      b = 0;
      while (resp_cnt < 3 && b < 30) begin cyc(); b++; end
      chk("dclr_fill_wait", resp_cnt, 3);
      dec_clear    = 1'b1;
      dec_set_addr = 32'h0000_2002;
      dec_accept   = 1'b1;
      cyc();
      dec_clear    = 1'b0;
      dec_accept   = 1'b0;
      chk("dclr_dec_valid", dec_valid, 1'b0);
      chk("dclr_req_valid", ic_req_valid, 1'b0);
`ifdef IF_PERF_CNT_EN
      chk("dclr_perf_flushed", perf_flushed, 32'd3);
      chk("dclr_perf_fetched", perf_fetched, 32'd3);
`endif
      repeat (8) cyc();
      chk("dclr_next_req", qat(req_log, 3), 32'h0000_2000);
      chk("dclr_new_valid", dec_valid, 1'b1);
      chk("dclr_new_addr", dec_inst_addr, 32'h0000_2000);
      chk("dclr_new_inst", dec_inst, 32'h0000_2000 ^ KEY);

      // ---- simultaneous ROB + decoder redirect while waiting for data ----
      do_reset();
      b = 0;
      while (req_log.size() < 1 && b < 10) begin cyc(); b++; end
      chk("both_fire_wait", req_log.size(), 1);
      hold_resp    = 1'b1;
      rob_clear    = 1'b1;
      rob_set_addr = 32'h0000_3000;
      dec_clear    = 1'b1;
      dec_set_addr = 32'h0000_4000;
      cyc();
      rob_clear    = 1'b0;
      dec_clear    = 1'b0;
      hold_resp    = 1'b0;
      chk("both_dec_valid", dec_valid, 1'b0);
      chk("both_req_valid0", ic_req_valid, 1'b0);
      cyc();
      chk("both_resp_taken", resp_cnt, 1);
      chk("both_req_valid1", ic_req_valid, 1'b0);
      chk("both_dec_valid1", dec_valid, 1'b0);
      cyc();
      chk("both_req_valid2", ic_req_valid, 1'b1);
      chk("both_req_addr", ic_req_addr, 32'h0000_3000);
`ifdef IF_PERF_CNT_EN
      chk("both_perf_flushed", perf_flushed, 32'd1);
      chk("both_perf_fetched", perf_fetched, 32'd0);
`endif
      repeat (6) cyc();
      chk("both_new_addr", dec_inst_addr, 32'h0000_3000);
      chk("both_new_inst", dec_inst, 32'h0000_3000 ^ KEY);

      // ---- redirect in the same cycle the request is accepted ----
      do_reset();
      b = 0;
      while (!ic_req_valid && b < 10) begin cyc(); b++; end
      chk("acc_req_wait", ic_req_valid, 1'b1);
      dec_clear    = 1'b1;
      dec_set_addr = 32'h0000_5000;
      cyc();
      dec_clear    = 1'b0;
      chk("acc_fired", req_log.size(), 1);
      chk("acc_req_valid", ic_req_valid, 1'b0);
      repeat (8) cyc();
      chk("acc_next_req", qat(req_log, 1), 32'h0000_5000);
      chk("acc_dec_valid", dec_valid, 1'b1);
      chk("acc_dec_addr", dec_inst_addr, 32'h0000_5000);
`ifdef IF_PERF_CNT_EN
      chk("acc_perf_flushed", perf_flushed, 32'd1);
      chk("acc_perf_fetched", perf_fetched, 32'd1);
`endif

      // ---- freeze with a pending response ----
      do_reset();
      b = 0;
      while (req_log.size() < 2 && b < 20) begin cyc(); b++; end
      chk("frz_fire_wait", req_log.size(), 2);
      rdy_in     = 1'b0;
      dec_accept = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("frz%0d_dec_valid", i), dec_valid, 1'b1);
         chk($sformatf("frz%0d_dec_addr", i), dec_inst_addr, RPC);
      end
      chk("frz_resp_held", resp_cnt, 1);
`ifdef IF_PERF_CNT_EN
      chk("frz_perf_fetched", perf_fetched, 32'd1);
`endif
      rdy_in     = 1'b1;
      dec_accept = 1'b0;
      cyc();
      chk("frz_resp_taken", resp_cnt, 2);
      chk("frz_head", dec_inst_addr, RPC);
      dec_accept = 1'b1;
      repeat (12) cyc();
      dec_accept = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("frz_pop%0d_addr", i), qat(pop_addr, i), RPC + 32'(4 * i));
         chk($sformatf("frz_pop%0d_inst", i), qat(pop_inst, i), (RPC + 32'(4 * i)) ^ KEY);
      end
      chk("frz_req2", qat(req_log, 2), 32'h0000_1008);

      // ---- 32-bit PC wrap ----
      do_reset();
      dec_clear    = 1'b1;
      dec_set_addr = 32'hFFFF_FFFF;
      cyc();
      dec_clear    = 1'b0;
      b = 0;
      while (req_log.size() < 2 && b < 20) begin cyc(); b++; end
      chk("wrap_req0", qat(req_log, 0), 32'hFFFF_FFFC);
      chk("wrap_req1", qat(req_log, 1), 32'h0000_0000);
      chk("wrap_head", dec_inst_addr, 32'hFFFF_FFFC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
